// File: rtl/acc_fb_pkg.sv
// Shared operation encodings for the feedback accumulator datapath.
package acc_fb_pkg;

  localparam int OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_ADD   = 2'b00,
    OP_SUB   = 2'b01,
    OP_LOAD  = 2'b10,
    OP_CLEAR = 2'b11
  } op_e;

endpackage

// File: rtl/fb_delay_line.sv
// Result history shift register; q is the value written DEPTH enabled shifts ago.
module fb_delay_line #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] hist [DEPTH];

  // NOTE: the history is a handful of flops, not a RAM, so every entry is
  // reset; a stale entry would leak into the first results after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) hist[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < DEPTH; i++) hist[i] <= '0;
    end else if (en) begin
      hist[0] <= d;
      for (int i = 1; i < DEPTH; i++) hist[i] <= hist[i-1];
    end
  end

  assign q = hist[DEPTH-1];

endmodule

// File: rtl/acc_feedback_unit.sv
// Streaming accumulator with delayed self-feedback, sticky overflow and sample count.
// Define ACC_FB_SATURATE_EN to clamp on carry/borrow instead of wrapping.
module acc_feedback_unit
  import acc_fb_pkg::*;
#(
  parameter int IN_W     = 4,
  parameter int OUT_W    = 8,
  parameter int FB_DEPTH = 1,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  a,
  input  logic [1:0]       op,
  input  logic             in_valid,
  output logic [OUT_W-1:0] result,
  output logic             out_valid,
  output logic             overflow,
  output logic [CNT_W-1:0] sample_cnt
);

  logic [OUT_W-1:0] fb;
  logic [OUT_W-1:0] a_ext;
  logic [OUT_W:0]   sum;
  logic [OUT_W:0]   diff;
  logic [OUT_W-1:0] next_result;
  logic             ovf_hit;
  logic             is_clear;
  op_e              op_q;

  assign op_q     = op_e'(op);
  assign a_ext    = OUT_W'(a);
  assign sum      = {1'b0, fb} + {1'b0, a_ext};
  assign diff     = {1'b0, fb} - {1'b0, a_ext};
  assign is_clear = (op_q == OP_CLEAR);

  // NOTE: defaults first so every path assigns every output; no latch is inferred.
  always_comb begin
    next_result = '0;
    ovf_hit     = 1'b0;
    case (op_q)
      OP_ADD: begin
        ovf_hit     = sum[OUT_W];
        next_result = sum[OUT_W-1:0];
`ifdef ACC_FB_SATURATE_EN
        if (sum[OUT_W]) next_result = '1;
`endif
      end
      OP_SUB: begin
        ovf_hit     = diff[OUT_W];
        next_result = diff[OUT_W-1:0];
`ifdef ACC_FB_SATURATE_EN
        if (diff[OUT_W]) next_result = '0;
`endif
      end
      OP_LOAD:  next_result = a_ext;
      default:  next_result = '0;
    endcase
  end

  fb_delay_line #(
    .WIDTH (OUT_W),
    .DEPTH (FB_DEPTH)
  ) u_hist (
    .clk (clk),
    .rst (rst),
    .en  (in_valid && !is_clear),
    .clr (in_valid && is_clear),
    .d   (next_result),
    .q   (fb)
  );

  // NOTE: sequential state uses non-blocking assignments so all registers
  // sample the same pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      result     <= '0;
      out_valid  <= 1'b0;
      overflow   <= 1'b0;
      sample_cnt <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        result <= next_result;
        if (is_clear) begin
          overflow   <= 1'b0;
          sample_cnt <= '0;
        end else begin
          if (ovf_hit) overflow <= 1'b1;
          if (sample_cnt != '1) sample_cnt <= sample_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_acc_feedback_unit.sv
// Randomised bench: two configurations checked every cycle against a history-log model.
module tb_acc_feedback_unit;

  localparam int MAX = 255;
  localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, LOAD = 2'b10, CLR = 2'b11;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] a = '0;
  logic [1:0] op = '0;
  logic       in_valid = 1'b0;

  logic [7:0] res0, res1, cnt0, cnt1;
  logic       ov0, ov1, of0, of1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Wide-input, single-delay configuration.
  acc_feedback_unit #(.IN_W(8), .OUT_W(8), .FB_DEPTH(1), .CNT_W(8)) dut0 (
    .clk(clk), .rst(rst), .a(a), .op(op), .in_valid(in_valid),
    .result(res0), .out_valid(ov0), .overflow(of0), .sample_cnt(cnt0));

  // Default 4-bit input, two-sample feedback delay.
  acc_feedback_unit #(.IN_W(4), .OUT_W(8), .FB_DEPTH(2), .CNT_W(8)) dut1 (
    .clk(clk), .rst(rst), .a(a[3:0]), .op(op), .in_valid(in_valid),
    .result(res1), .out_valid(ov1), .overflow(of1), .sample_cnt(cnt1));

  task automatic check(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a log of every result since the last clear/reset; feedback is the
  // entry `depth` positions back, or zero if the log is not that long yet.
  int log0[$];
  int log1[$];
  int m_res[2] = '{0, 0};
  int m_ovf[2] = '{0, 0};
  int m_cnt = 0;
  int m_ov  = 0;

  function automatic int get_fb(int k);
    if (k == 0) return (log0.size() >= 1) ? log0[log0.size()-1] : 0;
    return (log1.size() >= 2) ? log1[log1.size()-2] : 0;
  endfunction

  task automatic model_reset();
    log0.delete(); log1.delete();
    m_res = '{0, 0}; m_ovf = '{0, 0};
    m_cnt = 0; m_ov = 0;
  endtask

  task automatic model_apply(int k, int o, int av);
    int fb, r;
    fb = get_fb(k);
    r  = 0;
    case (o)
      0: begin
        r = fb + av;
        if (r > MAX) begin
          m_ovf[k] = 1;
`ifdef ACC_FB_SATURATE_EN
          r = MAX;
`else
          r = r - (MAX + 1);
`endif
        end
      end
      1: begin
        r = fb - av;
        if (r < 0) begin
          m_ovf[k] = 1;
`ifdef ACC_FB_SATURATE_EN
          r = 0;
`else
          r = r + MAX + 1;
`endif
        end
      end
      2: r = av;
      default: begin
        r = 0;
        m_ovf[k] = 0;
      end
    endcase
    m_res[k] = r;
    if (o == 3) begin
      if (k == 0) log0.delete(); else log1.delete();
    end else begin
      if (k == 0) log0.push_back(r); else log1.push_back(r);
    end
  endtask

  always @(negedge rst) model_reset();

  always @(posedge clk) begin
    if (rst) begin
      m_ov = in_valid;
      if (in_valid) begin
        model_apply(0, int'(op), int'(a));
        model_apply(1, int'(op), int'(a[3:0]));
        if (op == CLR) m_cnt = 0;
        else if (m_cnt < MAX) m_cnt++;
      end
    end
  end

  // Single compare process, half a cycle after each active edge.
  always @(negedge clk) begin
    check("res0", int'(res0), m_res[0]);
    check("res1", int'(res1), m_res[1]);
    check("ov0",  int'(ov0),  m_ov);
    check("ov1",  int'(ov1),  m_ov);
    check("of0",  int'(of0),  m_ovf[0]);
    check("of1",  int'(of1),  m_ovf[1]);
    check("cnt0", int'(cnt0), m_cnt);
    check("cnt1", int'(cnt1), m_cnt);
  end

  task automatic step(logic v, logic [1:0] o, logic [7:0] av);
    @(negedge clk);
    in_valid = v;
    op       = o;
    a        = av;
    @(posedge clk);
    #1;
  endtask

  task automatic mid_reset();
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("rst_res", int'(res0), 0);
    check("rst_ov",  int'(ov0), 0);
    check("rst_of",  int'(of0), 0);
    check("rst_cnt", int'(cnt1), 0);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Reset in the middle of a stream, then first sample sees fb = 0.
    step(1, ADD, 8'd5);
    step(1, ADD, 8'd5);
    mid_reset();
    step(1, ADD, 8'd7);
    check("t1_res0", int'(res0), 7);
    check("t1_res1", int'(res1), 7);

    // Plain accumulator and two-deep feedback side by side.
    step(1, CLR, 8'd0);
    check("clr_ov", int'(ov0), 1);
    step(1, ADD, 8'd5); check("t2_a", int'(res0), 5);
    step(1, ADD, 8'd5); check("t2_b", int'(res0), 10);
    step(1, ADD, 8'd5); check("t2_c", int'(res0), 15);
    check("t2_ov", int'(ov0), 1);
    check("t2_cnt", int'(cnt0), 3);
    check("t2_d2", int'(res1), 10);

    step(1, CLR, 8'd0);
    step(1, ADD, 8'd3); check("t3_a", int'(res1), 3);
    step(1, ADD, 8'd3); check("t3_b", int'(res1), 3);
    step(1, ADD, 8'd3); check("t3_c", int'(res1), 6);
    step(1, ADD, 8'd3); check("t3_d", int'(res1), 6);

    // Carry-out and sticky overflow.
    step(1, CLR, 8'd0);
    step(1, LOAD, 8'd250);
    step(1, ADD, 8'd10);
`ifdef ACC_FB_SATURATE_EN
    check("t4_res", int'(res0), 255);
`else
    check("t4_res", int'(res0), 4);
`endif
    check("t4_of", int'(of0), 1);
    step(1, LOAD, 8'd1);
    step(1, ADD, 8'd1);
    check("t4_sticky", int'(of0), 1);

    // Borrow, then CLEAR wipes everything.
    step(1, LOAD, 8'd2);
    step(1, SUB, 8'd5);
`ifdef ACC_FB_SATURATE_EN
    check("t5_res", int'(res0), 0);
`else
    check("t5_res", int'(res0), 253);
`endif
    check("t5_of", int'(of0), 1);
    step(1, CLR, 8'd9);
    check("t5_cres", int'(res0), 0);
    check("t5_cof",  int'(of0), 0);
    check("t5_ccnt", int'(cnt0), 0);
    check("t5_cov",  int'(ov0), 1);

    // Idle cycles hold state while a toggles.
    step(1, ADD, 8'd4); check("t6_a", int'(res0), 4);
    step(0, ADD, 8'd85); check("t6_h", int'(res0), 4); check("t6_hov", int'(ov0), 0);
    step(0, ADD, 8'd170); check("t6_h2", int'(res0), 4);
    step(1, ADD, 8'd4); check("t6_b", int'(res0), 8);
    for (int i = 0; i < 260; i++) step(1, ADD, 8'($urandom_range(0, 255)));
    check("t6_sat0", int'(cnt0), 255);
    check("t6_sat1", int'(cnt1), 255);

    // Random mixed traffic with a reset in the middle.
    for (int i = 0; i < 600; i++) begin
      int r;
      logic [1:0] o;
      r = $urandom_range(0, 15);
      o = (r == 0) ? CLR : 2'(r % 3);
      step(($urandom_range(0, 3) != 0), o, 8'($urandom_range(0, 255)));
      if (i == 300) mid_reset();
    end

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
